// File: rtl/mem_arbiter_if.sv
// Bundle of both requester handshakes plus the memory-side bus of mem_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  req0, we0, ack0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [7:0]            wdata0, rdata0;
    logic                  req1, we1, ack1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [7:0]            wdata1, rdata1;
    logic [ADDR_WIDTH-1:0] mem_raddr, mem_waddr;
    logic [7:0]            mem_data_in, mem_data_out;
    logic                  mem_write, grant, busy;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_data_out,
        output rdata0, ack0, rdata1, ack1, mem_raddr, mem_waddr, mem_data_in,
               mem_write, grant, busy
    );
    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_data_out,
        input  rdata0, ack0, rdata1, ack1, mem_raddr, mem_waddr, mem_data_in,
               mem_write, grant, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter in front of a fixed-latency byte memory;
// turns the memory's read latency into a per-port req/ack handshake.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, WR, DONE} state_e;

    state_e                     state_q, state_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic                       grant_q, grant_d, last_q, last_d;
    logic [ADDR_WIDTH-1:0]      raddr_q, raddr_d, waddr_q, waddr_d;
    logic [7:0]                 din_q, din_d;
    logic                       mwr_q, mwr_d;
    logic [1:0]                 ack_q, ack_d;
    logic [1:0][7:0]            rdata_q, rdata_d;

    logic [1:0]                 req, we;
    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][7:0]            wdata;
    logic                       pick;

    assign req   = {bus.req1, bus.req0};
    assign we    = {bus.we1, bus.we0};
    assign addr  = {bus.addr1, bus.addr0};
    assign wdata = {bus.wdata1, bus.wdata0};
    // On a tie the port that did not win last time goes first.
    assign pick  = (&req) ? ~last_q : req[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            raddr_q <= '0;
            waddr_q <= '0;
            din_q   <= '0;
            mwr_q   <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            din_q   <= din_d;
            mwr_q   <= mwr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = we[pick] ? WR : RD_WAIT;
                cnt_d   = 2'(READ_LATENCY - 1);
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) state_d = RD_CAP;
                else               cnt_d   = cnt_q - 2'd1;
            end
            RD_CAP:  state_d = DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        mwr_d   = 1'b0;
        ack_d   = '0;
        case (state_q)
            IDLE: if (|req) begin
                grant_d = pick;
                last_d  = pick;
                if (we[pick]) begin
                    waddr_d = addr[pick];
                    din_d   = wdata[pick];
                end else begin
                    raddr_d = addr[pick];
                end
            end
            RD_CAP: begin
                rdata_d[grant_q] = bus.mem_data_out;
                ack_d[grant_q]   = 1'b1;
            end
            // Address/data were registered in IDLE, so they lead the strobe by a cycle.
            WR: begin
                mwr_d          = 1'b1;
                ack_d[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ack0        = ack_q[0];
    assign bus.ack1        = ack_q[1];
    assign bus.rdata0      = rdata_q[0];
    assign bus.rdata1      = rdata_q[1];
    assign bus.mem_raddr   = raddr_q;
    assign bus.mem_waddr   = waddr_q;
    assign bus.mem_data_in = din_q;
    assign bus.mem_write   = mwr_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: DUT A (READ_LATENCY=1) and DUT B (READ_LATENCY=3),
// each with a behavioural byte memory of matching latency.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(9)) ifa ();
    mem_arbiter_if #(.ADDR_WIDTH(9)) ifb ();

    mem_arbiter #(.ADDR_WIDTH(9), .READ_LATENCY(1)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    mem_arbiter #(.ADDR_WIDTH(9), .READ_LATENCY(3)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    // Memory models with a preload port used only while the DUTs are in reset.
    logic [7:0] mem_a [512];
    logic [7:0] mem_b [512];
    logic       ld_en;
    logic [8:0] ld_addr;
    logic [7:0] ld_a, ld_b;
    logic [7:0] dout_a;
    logic [7:0] pipe_b [3];

    always @(posedge clk) begin
        if (ld_en) begin
            mem_a[ld_addr] <= ld_a;
            mem_b[ld_addr] <= ld_b;
        end else begin
            if (ifa.mem_write) mem_a[ifa.mem_waddr] <= ifa.mem_data_in;
            if (ifb.mem_write) mem_b[ifb.mem_waddr] <= ifb.mem_data_in;
        end
        dout_a    <= mem_a[ifa.mem_raddr];
        pipe_b[0] <= mem_b[ifb.mem_raddr];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign ifa.mem_data_out = dout_a;
    assign ifb.mem_data_out = pipe_b[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction on DUT A; returns negedges until ack, read data, grant, strobe count.
    task automatic op_a(input bit p, input bit w, input logic [8:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd, output logic g, output int wn);
        if (p) begin ifa.we1 = w; ifa.addr1 = a; ifa.wdata1 = d; ifa.req1 = 1'b1; end
        else   begin ifa.we0 = w; ifa.addr0 = a; ifa.wdata0 = d; ifa.req0 = 1'b1; end
        lat = 0; wn = 0; rd = '0; g = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (ifa.mem_write) wn++;
            if (p ? ifa.ack1 : ifa.ack0) break;
        end
        rd = p ? ifa.rdata1 : ifa.rdata0;
        g  = ifa.grant;
        chk("other_ack", p ? ifa.ack0 : ifa.ack1, 0);
        if (w) begin
            chk("wr_waddr", ifa.mem_waddr, a);
            chk("wr_data", ifa.mem_data_in, d);
        end
        if (p) ifa.req1 = 1'b0; else ifa.req0 = 1'b0;
        @(negedge clk);
        if (ifa.mem_write) wn++;
        chk("idle_busy", ifa.busy, 0);
    endtask

    int         lat, wn, t0, t1, nack, c0, c1, bad;
    logic [7:0] rd, rd1;
    logic       g, g0;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_a = '0; ld_b = '0;
        {ifa.req0, ifa.we0, ifa.addr0, ifa.wdata0} = '0;
        {ifa.req1, ifa.we1, ifa.addr1, ifa.wdata1} = '0;
        {ifb.req0, ifb.we0, ifb.addr0, ifb.wdata0} = '0;
        {ifb.req1, ifb.we1, ifb.addr1, ifb.wdata1} = '0;

        @(negedge clk);
        ld_en = 1'b1; ld_addr = 9'h010; ld_a = 8'hA5; ld_b = 8'h00;
        @(negedge clk);
        ld_addr = 9'h030; ld_a = 8'h5A;
        @(negedge clk);
        ld_addr = 9'h055; ld_a = 8'h00; ld_b = 8'h77;
        @(negedge clk);
        ld_en = 1'b0;

        chk("rst_ctl", {ifa.ack0, ifa.ack1, ifa.mem_write, ifa.grant, ifa.busy}, 0);
        chk("rst_addr", {ifa.mem_raddr, ifa.mem_waddr, ifa.mem_data_in}, 0);
        chk("rst_rdata", {ifa.rdata0, ifa.rdata1}, 0);

        // Reset in the middle of a port-0 read.
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.we0 = 1'b0; ifa.addr0 = 9'h010; ifa.req0 = 1'b1;
        @(negedge clk);
        chk("mid_busy", ifa.busy, 1);
        rst_a = 1'b0;
        #1;
        chk("mid_rst_outs", {ifa.busy, ifa.ack0, ifa.mem_raddr, ifa.grant}, 0);
        @(negedge clk);
        chk("mid_rst_ack", ifa.ack0, 0);
        rst_a = 1'b1;

        // Port-0 read after release, req0 still held.
        op_a(1'b0, 1'b0, 9'h010, 8'h00, lat, rd, g, wn);
        chk("rd0_lat", lat, 3);
        chk("rd0_data", rd, 8'hA5);
        chk("rd0_grant", g, 0);

        // Reset while in WR: the write must never reach memory.
        ifa.we1 = 1'b1; ifa.addr1 = 9'h030; ifa.wdata1 = 8'h99; ifa.req1 = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        ifa.req1 = 1'b0; rst_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_no_write", mem_a[9'h030], 8'h5A);

        // Port-1 write at the top address.
        op_a(1'b1, 1'b1, 9'h1FF, 8'h3C, lat, rd, g, wn);
        chk("wr1_lat", lat, 2);
        chk("wr1_strobes", wn, 1);
        chk("wr1_grant", g, 1);
        chk("wr1_mem", mem_a[9'h1FF], 8'h3C);

        // Simultaneous: port-0 write, port-1 read of same address; last grant was port 1.
        ifa.we0 = 1'b1; ifa.addr0 = 9'h020; ifa.wdata0 = 8'h12; ifa.req0 = 1'b1;
        ifa.we1 = 1'b0; ifa.addr1 = 9'h020; ifa.req1 = 1'b1;
        t0 = 0; t1 = 0; g0 = 1'b1; rd1 = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ifa.ack0) begin t0 = n; g0 = ifa.grant; ifa.req0 = 1'b0; end
            if (ifa.ack1) begin t1 = n; rd1 = ifa.rdata1; ifa.req1 = 1'b0; end
            if (t1 != 0) break;
        end
        ifa.req0 = 1'b0; ifa.req1 = 1'b0;
        chk("mix_t0", t0, 2);
        chk("mix_g0", g0, 0);
        chk("mix_t1", t1, 6);
        chk("mix_rd1", rd1, 8'h12);
        @(negedge clk);

        // Read-back of the port-1 write via port 0; port-1 rdata must hold.
        op_a(1'b0, 1'b0, 9'h1FF, 8'h00, lat, rd, g, wn);
        chk("rb_data", rd, 8'h3C);
        chk("rb_rdata1_hold", ifa.rdata1, 8'h12);

        // Continuous contention straight out of reset.
        rst_a = 1'b0;
        ifa.we0 = 1'b0; ifa.addr0 = 9'h010; ifa.req0 = 1'b1;
        ifa.we1 = 1'b0; ifa.addr1 = 9'h1FF; ifa.req1 = 1'b1;
        @(negedge clk);
        rst_a = 1'b1;
        nack = 0; c0 = 0; c1 = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (ifa.ack0 || ifa.ack1) begin
                chk($sformatf("cont_grant%0d", nack), ifa.grant, nack % 2);
                chk($sformatf("cont_time%0d", nack), n, 3 + 4 * nack);
                chk($sformatf("cont_data%0d", nack), ifa.grant ? ifa.rdata1 : ifa.rdata0,
                    (nack % 2) ? 8'h3C : 8'hA5);
                c0 += int'(ifa.ack0);
                c1 += int'(ifa.ack1);
                nack++;
                if (nack == 4) break;
            end
        end
        ifa.req0 = 1'b0; ifa.req1 = 1'b0;
        chk("cont_acks", nack, 4);
        chk("cont_split", c0 * 16 + c1, 2 * 16 + 2);
        @(negedge clk);

        // READ_LATENCY=3 read; busy must stay high until ack.
        ifb.we0 = 1'b0; ifb.addr0 = 9'h055; ifb.req0 = 1'b1;
        lat = 0; bad = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (!ifb.busy) bad++;
            if (ifb.ack0) break;
        end
        chk("l3_lat", lat, 5);
        chk("l3_data", ifb.rdata0, 8'h77);
        chk("l3_busy_hi", bad, 0);
        chk("l3_ack1", ifb.ack1, 0);
        ifb.req0 = 1'b0;
        @(negedge clk);
        chk("l3_busy_lo", ifb.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
